// File: rtl/rotary_preset_entry_pkg.sv
// Shared definitions for the rotary preset entry block: digit indices,
// per-digit BCD limits, switch FSM states, quadrature accumulator limits,
// and small helper functions for the quadrature and BCD arithmetic.
package rotary_preset_entry_pkg;

  localparam logic [1:0] DIG_S1  = 2'd0;
  localparam logic [1:0] DIG_S10 = 2'd1;
  localparam logic [1:0] DIG_M1  = 2'd2;
  localparam logic [1:0] DIG_M10 = 2'd3;

  // Filtered {A,B} level at a mechanical detent.
  localparam logic [1:0] AB_DETENT = 2'b11;

  localparam logic signed [3:0] ACC_MAX = 4'sd4;
  localparam logic signed [3:0] ACC_MIN = -4'sd4;

  typedef enum logic [1:0] {
    SW_IDLE    = 2'd0,
    SW_PRESSED = 2'd1,
    SW_LONG    = 2'd2
  } sw_state_t;

  // Largest legal value of the selected BCD digit (units 9, tens 5).
  function automatic logic [3:0] dig_max(input logic [1:0] sel);
    case (sel)
      DIG_S1:  return 4'd9;
      DIG_S10: return 4'd5;
      DIG_M1:  return 4'd9;
      default: return 4'd5;
    endcase
  endfunction

  // Next {A,B} state when turning clockwise: 11 -> 10 -> 00 -> 01 -> 11.
  function automatic logic [1:0] cw_next(input logic [1:0] ab);
    case (ab)
      2'b11:   return 2'b10;
      2'b10:   return 2'b00;
      2'b00:   return 2'b01;
      default: return 2'b11;
    endcase
  endfunction

  // One BCD digit step with wrap between 0 and vmax.
  function automatic logic [3:0] bcd_step(input logic [3:0] v,
                                          input logic [3:0] vmax,
                                          input logic       up);
    if (up) return (v >= vmax) ? 4'd0 : v + 4'd1;
    else    return (v == 4'd0) ? vmax : v - 4'd1;
  endfunction

endpackage

// File: rtl/rotary_preset_entry_sample_filter.sv
// Two-flop synchroniser followed by a run-length level filter.
// The filtered level only moves after the synchronised input has disagreed
// with it on FILT_SAMPLES consecutive sample enables.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   div_clk  in  sample enable, one clk wide
//   raw      in  asynchronous raw input
//   filt     out filtered level (RST_VAL after reset)
module rotary_preset_entry_sample_filter #(
  parameter int FILT_SAMPLES = 3,
  parameter bit RST_VAL      = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic div_clk,
  input  logic raw,
  output logic filt
);

  localparam int CNT_W = (FILT_SAMPLES < 2) ? 1 : $clog2(FILT_SAMPLES);

  logic             sync_p0;
  logic             sync_p1;
  logic [CNT_W-1:0] run_cnt;

  // Stage p0/p1: metastability synchroniser
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= RST_VAL;
      sync_p1 <= RST_VAL;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: run-length filter, advanced only on sample enables
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
      filt    <= RST_VAL;
    end else if (div_clk) begin
      if (sync_p1 == filt) begin
        run_cnt <= '0;
      end else if (run_cnt == CNT_W'(FILT_SAMPLES - 1)) begin
        filt    <= sync_p1;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/rotary_preset_entry.sv
// Rotary encoder preset entry: decodes a detented quadrature encoder and its
// push switch, edits a 4-digit BCD mm.ss preset and issues LOAD on long press.
//   CLK        in   system clock
//   RESET      in   asynchronous active-low reset
//   DIV_CLK    in   1 kHz sample enable, one CLK wide
//   ENC_A/B    in   raw encoder phases
//   ENC_SW     in   raw push switch, active-low
//   DIGIT_SEL  out  digit under edit (0=S1,1=S10,2=M1,3=M10)
//   PRESET     out  {M10,M1,S10,S1} BCD
//   STEP_UP    out  one-cycle pulse per clockwise detent
//   STEP_DN    out  one-cycle pulse per counter-clockwise detent
//   LOAD       out  one-cycle pulse on long press
module rotary_preset_entry #(
  parameter int FILT_SAMPLES = 3,
  parameter int LONG_TICKS   = 1000,
  parameter int HOLD_W       = 10
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        DIV_CLK,
  input  logic        ENC_A,
  input  logic        ENC_B,
  input  logic        ENC_SW,
  output logic [1:0]  DIGIT_SEL,
  output logic [15:0] PRESET,
  output logic        STEP_UP,
  output logic        STEP_DN,
  output logic        LOAD
);
  import rotary_preset_entry_pkg::*;

  logic              filt_a;
  logic              filt_b;
  logic              filt_sw;
  logic [1:0]        ab_now;
  logic [1:0]        ab_p0;
  logic              sw_p0;
  logic signed [3:0] acc;
  logic signed [3:0] acc_nxt;
  logic              step_up_nxt;
  logic              step_dn_nxt;
  sw_state_t         sw_state;
  logic [HOLD_W-1:0] hold;

  // Accumulator add with clamping to ACC_MIN..ACC_MAX.
  function automatic logic signed [3:0] sat_acc(input logic signed [3:0] a,
                                                input logic signed [3:0] d);
    logic signed [4:0] s;
    s = $signed({a[3], a}) + $signed({d[3], d});
    if (s > ACC_MAX) return ACC_MAX;
    if (s < ACC_MIN) return ACC_MIN;
    return s[3:0];
  endfunction

  // Stage p0..p2: per-input synchroniser and level filter
  rotary_preset_entry_sample_filter #(.FILT_SAMPLES(FILT_SAMPLES), .RST_VAL(1'b1)) u_filt_a (
    .clk(CLK), .rst_n(RESET), .div_clk(DIV_CLK), .raw(ENC_A), .filt(filt_a)
  );
  rotary_preset_entry_sample_filter #(.FILT_SAMPLES(FILT_SAMPLES), .RST_VAL(1'b1)) u_filt_b (
    .clk(CLK), .rst_n(RESET), .div_clk(DIV_CLK), .raw(ENC_B), .filt(filt_b)
  );
  rotary_preset_entry_sample_filter #(.FILT_SAMPLES(FILT_SAMPLES), .RST_VAL(1'b1)) u_filt_sw (
    .clk(CLK), .rst_n(RESET), .div_clk(DIV_CLK), .raw(ENC_SW), .filt(filt_sw)
  );

  assign ab_now = {filt_a, filt_b};

  // Only single-bit Gray moves count; a double-bit jump is ignored entirely.
  always_comb begin
    acc_nxt     = acc;
    step_up_nxt = 1'b0;
    step_dn_nxt = 1'b0;
    if ((ab_now != ab_p0) && (ab_now != ~ab_p0)) begin
      if (ab_now == cw_next(ab_p0)) acc_nxt = sat_acc(acc, 4'sd1);
      else                          acc_nxt = sat_acc(acc, -4'sd1);
      if (ab_now == AB_DETENT) begin
        step_up_nxt = (acc_nxt == ACC_MAX);
        step_dn_nxt = (acc_nxt == ACC_MIN);
        acc_nxt     = '0;
      end
    end
  end

  // Stage p3: step pulses and digit edit (uses DIGIT_SEL before any advance)
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ab_p0   <= AB_DETENT;
      acc     <= '0;
      STEP_UP <= 1'b0;
      STEP_DN <= 1'b0;
      PRESET  <= '0;
    end else begin
      ab_p0   <= ab_now;
      acc     <= acc_nxt;
      STEP_UP <= step_up_nxt;
      STEP_DN <= step_dn_nxt;
      if (step_up_nxt || step_dn_nxt)
        PRESET[{DIGIT_SEL, 2'b00} +: 4] <= bcd_step(PRESET[{DIGIT_SEL, 2'b00} +: 4],
                                                    dig_max(DIGIT_SEL), step_up_nxt);
    end
  end

  // Stage p3: switch FSM, digit select and LOAD
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      sw_state  <= SW_IDLE;
      sw_p0     <= 1'b1;
      hold      <= '0;
      DIGIT_SEL <= DIG_S1;
      LOAD      <= 1'b0;
    end else begin
      sw_p0 <= filt_sw;
      LOAD  <= 1'b0;
      case (sw_state)
        SW_IDLE: begin
          if (sw_p0 && !filt_sw) begin
            sw_state <= SW_PRESSED;
            hold     <= '0;
          end
        end
        SW_PRESSED: begin
          if (filt_sw) begin
            sw_state  <= SW_IDLE;
            DIGIT_SEL <= DIGIT_SEL + 2'd1;
          end else if (DIV_CLK) begin
            if (hold == HOLD_W'(LONG_TICKS - 1)) begin
              sw_state <= SW_LONG;
              LOAD     <= 1'b1;
            end else begin
              hold <= hold + HOLD_W'(1);
            end
          end
        end
        SW_LONG: begin
          if (filt_sw) sw_state <= SW_IDLE;
        end
        default: sw_state <= SW_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotary_preset_entry.sv
// Self-checking bench for rotary_preset_entry: directed scenarios followed by
// randomized encoder turns and presses, compared against a digit-level model.
module tb_rotary_preset_entry;

  localparam int FILT_SAMPLES = 3;
  localparam int LONG_TICKS   = 1000;
  localparam int HOLD_W       = 10;
  localparam int DIV_PERIOD   = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        DIV_CLK;
  logic        ENC_A;
  logic        ENC_B;
  logic        ENC_SW;
  logic [1:0]  DIGIT_SEL;
  logic [15:0] PRESET;
  logic        STEP_UP;
  logic        STEP_DN;
  logic        LOAD;

  int checks = 0;
  int errors = 0;

  int div_cnt  = 0;
  int tick_cnt = 0;

  int up_cnt = 0, dn_cnt = 0, load_cnt = 0, both_cnt = 0, fa_chg = 0;
  int load_tick = 0;
  logic [15:0] load_preset = '0;
  logic prev_fa = 1'b1;

  // Reference model: four decimal digits, selected index, expected pulse totals.
  int m_dig[4];
  int m_sel;
  int exp_up = 0, exp_dn = 0;

  rotary_preset_entry #(
    .FILT_SAMPLES(FILT_SAMPLES), .LONG_TICKS(LONG_TICKS), .HOLD_W(HOLD_W)
  ) dut (
    .CLK(CLK), .RESET(RESET), .DIV_CLK(DIV_CLK),
    .ENC_A(ENC_A), .ENC_B(ENC_B), .ENC_SW(ENC_SW),
    .DIGIT_SEL(DIGIT_SEL), .PRESET(PRESET),
    .STEP_UP(STEP_UP), .STEP_DN(STEP_DN), .LOAD(LOAD)
  );

  always #5 CLK = ~CLK;

  initial begin
    DIV_CLK = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      div_cnt = (div_cnt == DIV_PERIOD - 1) ? 0 : div_cnt + 1;
      DIV_CLK = (div_cnt == 0);
      if (div_cnt == 0) tick_cnt = tick_cnt + 1;
    end
  end

  always @(negedge CLK) begin
    if (RESET) begin
      if (STEP_UP) up_cnt <= up_cnt + 1;
      if (STEP_DN) dn_cnt <= dn_cnt + 1;
      if (STEP_UP && STEP_DN) both_cnt <= both_cnt + 1;
      if (LOAD) begin
        load_cnt    <= load_cnt + 1;
        load_tick   <= tick_cnt;
        load_preset <= PRESET;
      end
      if (dut.filt_a != prev_fa) fa_chg <= fa_chg + 1;
    end
    prev_fa <= dut.filt_a;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_preset();
    return {4'(m_dig[3]), 4'(m_dig[2]), 4'(m_dig[1]), 4'(m_dig[0])};
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 4; i++) m_dig[i] = 0;
    m_sel = 0;
  endfunction

  function automatic void m_turn(input bit cw);
    int base;
    base = ((m_sel % 2) == 0) ? 10 : 6;
    if (cw) begin
      m_dig[m_sel] = (m_dig[m_sel] + 1) % base;
      exp_up++;
    end else begin
      m_dig[m_sel] = (m_dig[m_sel] + base - 1) % base;
      exp_dn++;
    end
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n * DIV_PERIOD) @(posedge CLK);
    #2;
  endtask

  task automatic turn(input bit cw, input int hold_t);
    logic [1:0] seq[4];
    if (cw) seq = '{2'b10, 2'b00, 2'b01, 2'b11};
    else    seq = '{2'b01, 2'b00, 2'b10, 2'b11};
    for (int i = 0; i < 4; i++) begin
      {ENC_A, ENC_B} = seq[i];
      wait_ticks(hold_t);
    end
  endtask

  task automatic detent(input bit cw, input int hold_t, input string tag);
    turn(cw, hold_t);
    m_turn(cw);
    check_val(tag, {16'h0, PRESET}, {16'h0, m_preset()});
  endtask

  task automatic short_press(input int dur);
    ENC_SW = 1'b0;
    wait_ticks(dur);
    ENC_SW = 1'b1;
    wait_ticks(6);
    m_sel = (m_sel + 1) % 4;
    check_val("short_press_sel", {30'h0, DIGIT_SEL}, 32'(m_sel));
  endtask

  initial begin
    int up0, dn0, l0, t0, lat;
    logic [15:0] p0;
    RESET = 1'b0; ENC_A = 1'b1; ENC_B = 1'b1; ENC_SW = 1'b1;
    m_reset();
    repeat (5) @(negedge CLK);
    check_val("reset_outputs", {11'h0, DIGIT_SEL, PRESET, STEP_UP, STEP_DN, LOAD}, 32'h0);
    @(posedge CLK); #2;
    RESET = 1'b1;
    wait_ticks(6);

    // One clean CW detent, 5 ticks per state.
    up0 = up_cnt;
    detent(1'b1, 5, "first_cw_preset");
    check_val("first_cw_value", {16'h0, PRESET}, 32'h0001);
    check_val("first_cw_pulses", 32'(up_cnt - up0), 32'd1);

    // Nine more CW detents: S1 wraps 9 -> 0 without carrying.
    for (int i = 0; i < 9; i++) detent(1'b1, $urandom_range(4, 6), "cw_run_preset");
    check_val("s1_wrap", {16'h0, PRESET}, 32'h0000);

    // Short press, then seven CCW detents on S10.
    short_press(200);
    dn0 = dn_cnt;
    for (int i = 0; i < 7; i++) detent(1'b0, 5, "ccw_s10_preset");
    check_val("s10_final", {16'h0, PRESET}, 32'h0050);
    check_val("ccw_pulses", 32'(dn_cnt - dn0), 32'd7);

    // Half detent then reverse.
    up0 = up_cnt; dn0 = dn_cnt; p0 = PRESET;
    {ENC_A, ENC_B} = 2'b10; wait_ticks(5);
    {ENC_A, ENC_B} = 2'b00; wait_ticks(5);
    {ENC_A, ENC_B} = 2'b10; wait_ticks(5);
    {ENC_A, ENC_B} = 2'b11; wait_ticks(5);
    check_val("half_detent_pulses", 32'((up_cnt - up0) + (dn_cnt - dn0)), 32'd0);
    check_val("half_detent_acc", {28'h0, dut.acc}, 32'h0);
    check_val("half_detent_preset", {16'h0, PRESET}, {16'h0, p0});

    // Short glitches on A only.
    t0 = fa_chg;
    ENC_A = 1'b0; wait_ticks(1);
    ENC_A = 1'b1; wait_ticks(5);
    ENC_A = 1'b0; wait_ticks(2);
    ENC_A = 1'b1; wait_ticks(6);
    check_val("glitch_filt_a", 32'(fa_chg - t0), 32'd0);
    check_val("glitch_pulses", 32'((up_cnt - up0) + (dn_cnt - dn0)), 32'd0);

    // Illegal 11 -> 00 jump and back.
    {ENC_A, ENC_B} = 2'b00; wait_ticks(6);
    {ENC_A, ENC_B} = 2'b11; wait_ticks(6);
    check_val("illegal_pulses", 32'((up_cnt - up0) + (dn_cnt - dn0)), 32'd0);
    check_val("illegal_preset", {16'h0, PRESET}, {16'h0, m_preset()});

    // Long press: exactly one LOAD after about LONG_TICKS ticks.
    l0 = load_cnt; t0 = tick_cnt;
    ENC_SW = 1'b0;
    wait_ticks(1500);
    ENC_SW = 1'b1;
    wait_ticks(6);
    lat = load_tick - t0;
    check_val("long_load_count", 32'(load_cnt - l0), 32'd1);
    check_val("long_load_latency",
              {31'h0, (lat >= LONG_TICKS) && (lat <= LONG_TICKS + FILT_SAMPLES + 2)}, 32'd1);
    check_val("long_load_preset", {16'h0, load_preset}, {16'h0, m_preset()});
    check_val("long_sel_kept", {30'h0, DIGIT_SEL}, 32'(m_sel));

    // Reset in the middle of a hold.
    l0 = load_cnt;
    ENC_SW = 1'b0;
    wait_ticks(300);
    RESET = 1'b0;
    @(negedge CLK);
    check_val("midhold_reset_outputs", {11'h0, DIGIT_SEL, PRESET, STEP_UP, STEP_DN, LOAD}, 32'h0);
    ENC_SW = 1'b1;
    repeat (3) @(posedge CLK); #2;
    RESET = 1'b1;
    m_reset();
    wait_ticks(LONG_TICKS + 50);
    check_val("midhold_no_load", 32'(load_cnt - l0), 32'd0);
    check_val("midhold_sel", {30'h0, DIGIT_SEL}, 32'(m_sel));
    check_val("midhold_preset", {16'h0, PRESET}, {16'h0, m_preset()});

    // Randomized mix of turns and presses.
    for (int n = 0; n < 40; n++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op < 2) begin
        detent(op == 0, $urandom_range(4, 7), "rand_turn_preset");
      end else if (op == 2) begin
        short_press($urandom_range(4, 60));
      end else begin
        bit cw;
        cw = 1'($urandom_range(0, 1));
        ENC_SW = 1'b0;
        wait_ticks(5);
        detent(cw, 4, "rand_turn_pressed_preset");
        ENC_SW = 1'b1;
        wait_ticks(6);
        m_sel = (m_sel + 1) % 4;
        check_val("rand_turn_pressed_sel", {30'h0, DIGIT_SEL}, 32'(m_sel));
      end
    end
    check_val("total_up", 32'(up_cnt), 32'(exp_up));
    check_val("total_dn", 32'(dn_cnt), 32'(exp_dn));
    check_val("never_both", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
